// File: rtl/fp_add_pkg.sv
// Shared constants and state codes for the floating-point adder control path.
package fp_add_pkg;

    localparam int EXP_W     = 8;
    localparam int MANT_W    = 24;
    localparam int MAX_ALIGN = MANT_W + 2;
    localparam logic [EXP_W-1:0] EXP_MAX_FINITE = 8'd254;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_LOAD  = 3'd1;
    localparam state_t S_CMP   = 3'd2;
    localparam state_t S_ALIGN = 3'd3;
    localparam state_t S_ADD   = 3'd4;
    localparam state_t S_NORM  = 3'd5;
    localparam state_t S_DONE  = 3'd6;

endpackage

// File: rtl/fp_step_counter.sv
// Loadable up/down step counter; a load larger than SAT is clamped to SAT.
module fp_step_counter #(
    parameter int W    = 5,
    parameter int IN_W = 8,
    parameter int SAT  = 26
) (
    input  logic            clk,
    input  logic            clear_n,
    input  logic            load,
    input  logic [IN_W-1:0] load_val,
    input  logic            inc,
    input  logic            dec,
    output logic [W-1:0]    cnt
);

    localparam logic [IN_W-1:0] SAT_IN = IN_W'(SAT);
    localparam logic [W-1:0]    SAT_W  = W'(SAT);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            cnt <= '0;
        else if (load)
            cnt <= (load_val > SAT_IN) ? SAT_W : W'(load_val);
        else if (inc)
            cnt <= cnt + 1'b1;
        else if (dec)
            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/fp_add_ctrl.sv
// Control FSM for the FP adder: load, compare, align, add, normalize, done.
// Strobes are decoded from the current state; NORM also looks at sum status.
module fp_add_ctrl #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 24,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic             exp_a_ge_b,
    input  logic [EXP_W-1:0] exp_diff,
    input  logic             special,
    input  logic             sum_carry,
    input  logic             sum_msb,
    input  logic             sum_zero,
    input  logic [EXP_W-1:0] exp_cur,
    output logic             load_ops,
    output logic             load_exp,
    output logic             exp_sel,
    output logic             clear_exp,
    output logic             shift_small,
    output logic             add_en,
    output logic             norm_right,
    output logic             norm_left,
    output logic             exp_inc,
    output logic             exp_dec,
    output logic             load_result,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             underflow,
    output logic             zero_res
);

    import fp_add_pkg::*;

    state_t           state, nxt;
    logic [CNT_W-1:0] acnt, ncnt;
    logic             set_ovf, set_unf, set_zero;
    logic             accept;

    fp_step_counter #(.W(CNT_W), .IN_W(EXP_W), .SAT(MAX_ALIGN)) u_align_cnt (
        .clk      (clk),
        .clear_n  (clear_n),
        .load     (state == S_CMP),
        .load_val (exp_diff),
        .inc      (1'b0),
        .dec      (state == S_ALIGN),
        .cnt      (acnt)
    );

    fp_step_counter #(.W(CNT_W), .IN_W(EXP_W), .SAT(MANT_W-1)) u_norm_cnt (
        .clk      (clk),
        .clear_n  (clear_n),
        .load     (state == S_ADD),
        .load_val ('0),
        .inc      (norm_left),
        .dec      (1'b0),
        .cnt      (ncnt)
    );

    assign accept = (state == S_IDLE) && start;
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt         = state;
        load_ops    = 1'b0;
        load_exp    = 1'b0;
        exp_sel     = 1'b0;
        clear_exp   = 1'b0;
        shift_small = 1'b0;
        add_en      = 1'b0;
        norm_right  = 1'b0;
        norm_left   = 1'b0;
        exp_inc     = 1'b0;
        exp_dec     = 1'b0;
        load_result = 1'b0;
        done        = 1'b0;
        set_ovf     = 1'b0;
        set_unf     = 1'b0;
        set_zero    = 1'b0;
        case (state)
            S_IDLE: if (start) nxt = S_LOAD;
            S_LOAD: begin
                load_ops = 1'b1;
                nxt      = S_CMP;
            end
            S_CMP: begin
                load_exp = 1'b1;
                exp_sel  = exp_a_ge_b;
                if (special)
                    nxt = S_DONE;
                else if (exp_diff == '0)
                    nxt = S_ADD;
                else
                    nxt = S_ALIGN;
            end
            S_ALIGN: begin
                shift_small = 1'b1;
                if (acnt == CNT_W'(1)) nxt = S_ADD;
            end
            S_ADD: begin
                add_en = 1'b1;
                nxt    = S_NORM;
            end
            S_NORM: begin
                if (sum_zero) begin
                    clear_exp = 1'b1;
                    set_zero  = 1'b1;
                    nxt       = S_DONE;
                end else if (sum_carry) begin
                    // carry shift stays in NORM so the shifted sum is re-checked
                    norm_right = 1'b1;
                    exp_inc    = 1'b1;
                    if (exp_cur == EXP_MAX_FINITE) begin
                        set_ovf = 1'b1;
                        nxt     = S_DONE;
                    end
                end else if (sum_msb) begin
                    nxt = S_DONE;
                end else if (exp_cur <= EXP_W'(1)) begin
                    set_unf = 1'b1;
                    nxt     = S_DONE;
                end else begin
                    norm_left = 1'b1;
                    exp_dec   = 1'b1;
                    if (ncnt == CNT_W'(MANT_W-2)) nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                load_result = 1'b1;
                nxt         = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            zero_res  <= 1'b0;
        end else if (accept) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            zero_res  <= 1'b0;
        end else begin
            overflow  <= overflow  | set_ovf;
            underflow <= underflow | set_unf;
            zero_res  <= zero_res  | set_zero;
        end
    end

endmodule
